// File: rtl/l1_fill_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : l1_fill_unit_pkg
//  Description : Shared block/chunk types for the L1 block cache and its
//                refill engine: block coordinates, block type, the invalid
//                tag coordinate, and the chunk-address mapping function.
//  Revision    : 1.0 - initial release
// ============================================================================
package l1_fill_unit_pkg;

  localparam int CHUNK_WIDTH = 16;
  localparam int COORD_W     = $clog2(CHUNK_WIDTH);
  localparam int ADDR_W      = 3 * COORD_W;
  localparam int BLOCK_W     = 8;

  typedef logic signed [COORD_W-1:0] coord_t;

  typedef struct packed {
    coord_t x;
    coord_t y;
    coord_t z;
  } BlockPos;

  typedef logic [BLOCK_W-1:0] BlockType;

  localparam BlockType BLOCK_AIR = '0;

  // Most negative coordinate; never a real position, so it doubles as the
  // "empty" tag written into cache entries on reset.
  localparam coord_t TAG_INVALID = coord_t'(-(CHUNK_WIDTH / 2));

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_READ = 3'd1,
    ST_WAIT = 3'd2,
    ST_FILL = 3'd3,
    ST_SKIP = 3'd4
  } fill_state_e;

  // Two's-complement coordinates become offset binary by flipping the sign
  // bit, giving a dense unsigned {x,y,z} chunk address.
  function automatic logic [ADDR_W-1:0] block_pos_to_addr(input BlockPos p);
    return {~p.x[COORD_W-1], p.x[COORD_W-2:0],
            ~p.y[COORD_W-1], p.y[COORD_W-2:0],
            ~p.z[COORD_W-1], p.z[COORD_W-2:0]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/l1_fill_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : l1_fill_unit_if
//  Description : Bundle of miss-request, chunk-BRAM and cache-fill signals
//                around the L1 fill unit.
//  Revision    : 1.0 - initial release
//  Ports       : master - fill unit side (drives done/mem/fill/busy)
//                slave  - environment side (drives miss requests, mem_data)
// ============================================================================
interface l1_fill_unit_if #(
  parameter int PORTS      = 4,
  parameter int CACHE_SIZE = 16
);
  import l1_fill_unit_pkg::*;

  logic    [PORTS-1:0]              miss_valid;
  BlockPos [PORTS-1:0]              miss_addr;
  logic    [PORTS-1:0]              miss_done;
  logic                             mem_en;
  logic    [ADDR_W-1:0]             mem_addr;
  BlockType                         mem_data;
  logic                             fill_valid;
  logic    [$clog2(CACHE_SIZE)-1:0] fill_index;
  BlockPos                          fill_tag;
  BlockType                         fill_data;
  logic                             busy;

  modport master (
    input  miss_valid, miss_addr, mem_data,
    output miss_done, mem_en, mem_addr, fill_valid, fill_index,
           fill_tag, fill_data, busy
  );

  modport slave (
    output miss_valid, miss_addr, mem_data,
    input  miss_done, mem_en, mem_addr, fill_valid, fill_index,
           fill_tag, fill_data, busy
  );

endinterface
`default_nettype wire

// File: rtl/l1_fill_unit_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin grant: first set request at or
//                after the pointer, wrapping around.
//  Revision    : 1.0 - initial release
//  Ports       : req_i       - request vector
//                ptr_i       - highest-priority index
//                any_o       - at least one request set
//                grant_oh_o  - one-hot grant
//                grant_idx_o - binary grant index
// ============================================================================
module rr_arbiter #(
  parameter int N = 4
) (
  input  wire logic [N-1:0]                        req_i,
  input  wire logic [((N > 1) ? $clog2(N) : 1)-1:0] ptr_i,
  output logic                                     any_o,
  output logic [N-1:0]                             grant_oh_o,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0]     grant_idx_o
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int JW = IW + 1;

  always_comb begin
    logic [JW-1:0] j;
    j           = '0;
    any_o       = 1'b0;
    grant_oh_o  = '0;
    grant_idx_o = '0;
    for (int i = 0; i < N; i++) begin
      // ptr + i is below 2N, so one conditional subtract wraps it.
      j = {1'b0, ptr_i} + JW'(i);
      if (j >= JW'(N)) j = j - JW'(N);
      if (!any_o && req_i[j[IW-1:0]]) begin
        any_o                  = 1'b1;
        grant_oh_o[j[IW-1:0]]  = 1'b1;
        grant_idx_o            = j[IW-1:0];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/l1_fill_unit.sv
`default_nettype none
// ============================================================================
//  Module      : l1_fill_unit
//  Description : L1 block-cache miss handler. Arbitrates round-robin among
//                missing ports, reads the block from chunk BRAM, and writes
//                one cache entry with cyclic replacement. Misses to the same
//                position are resolved together.
//  Revision    : 1.0 - initial release
//  Ports       : clk_in - clock
//                rst_in - asynchronous active-low reset
//                bus    - miss requests / done, chunk BRAM, cache fill, busy
// ============================================================================
module l1_fill_unit
  import l1_fill_unit_pkg::*;
#(
  parameter int PORTS       = 4,
  parameter int CACHE_SIZE  = 16,
  parameter int MEM_LATENCY = 2
) (
  input wire logic       clk_in,
  input wire logic       rst_in,
  l1_fill_unit_if.master bus
);

  localparam int PW = (PORTS > 1) ? $clog2(PORTS) : 1;
  localparam int RW = $clog2(CACHE_SIZE);
  localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  fill_state_e     state_q;
  logic [PW-1:0]   rr_ptr_q;
  logic [RW-1:0]   repl_ptr_q;
  logic [CW-1:0]   cnt_q;
  logic [PORTS-1:0] gnt_oh_q;
  BlockPos         addr_q;

  logic [PORTS-1:0]  miss_done_q;
  logic              mem_en_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic              fill_valid_q;
  logic [RW-1:0]     fill_index_q;
  BlockPos           fill_tag_q;
  BlockType          fill_data_q;
  logic              busy_q;

  logic             any_req;
  logic [PORTS-1:0] grant_oh;
  logic [PW-1:0]    grant_idx;
  BlockPos          sel_addr;
  logic             sel_invalid;
  logic [PORTS-1:0] done_d;

  rr_arbiter #(.N(PORTS)) u_arb (
    .req_i       (bus.miss_valid),
    .ptr_i       (rr_ptr_q),
    .any_o       (any_req),
    .grant_oh_o  (grant_oh),
    .grant_idx_o (grant_idx)
  );

  assign sel_addr    = bus.miss_addr[grant_idx];
  assign sel_invalid = (sel_addr.x == TAG_INVALID) || (sel_addr.y == TAG_INVALID) ||
                       (sel_addr.z == TAG_INVALID);

  // Granted port is always resolved, even if it dropped its request early;
  // any other live request for the same position rides along.
  always_comb begin
    done_d = gnt_oh_q;
    for (int i = 0; i < PORTS; i++) begin
      if (bus.miss_valid[i] && (bus.miss_addr[i] == addr_q)) done_d[i] = 1'b1;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q      <= ST_IDLE;
      rr_ptr_q     <= '0;
      repl_ptr_q   <= '0;
      cnt_q        <= '0;
      gnt_oh_q     <= '0;
      addr_q       <= '0;
      miss_done_q  <= '0;
      mem_en_q     <= 1'b0;
      mem_addr_q   <= '0;
      fill_valid_q <= 1'b0;
      fill_index_q <= '0;
      fill_tag_q   <= '0;
      fill_data_q  <= BLOCK_AIR;
      busy_q       <= 1'b0;
    end else begin
      // Strobes and their payloads are single-cycle.
      miss_done_q  <= '0;
      mem_en_q     <= 1'b0;
      mem_addr_q   <= '0;
      fill_valid_q <= 1'b0;
      fill_index_q <= '0;
      fill_tag_q   <= '0;
      fill_data_q  <= BLOCK_AIR;
      case (state_q)
        ST_IDLE: begin
          if (any_req) begin
            gnt_oh_q <= grant_oh;
            addr_q   <= sel_addr;
            rr_ptr_q <= (grant_idx == PW'(PORTS - 1)) ? '0 : grant_idx + PW'(1);
            busy_q   <= 1'b1;
            if (sel_invalid) begin
              state_q     <= ST_SKIP;
              miss_done_q <= grant_oh;
            end else begin
              state_q    <= ST_READ;
              mem_en_q   <= 1'b1;
              mem_addr_q <= block_pos_to_addr(sel_addr);
            end
          end
        end
        ST_READ: begin
          state_q <= ST_WAIT;
          cnt_q   <= CW'(MEM_LATENCY - 1);
        end
        ST_WAIT: begin
          if (cnt_q == '0) begin
            state_q      <= ST_FILL;
            fill_valid_q <= 1'b1;
            fill_index_q <= repl_ptr_q;
            fill_tag_q   <= addr_q;
            fill_data_q  <= bus.mem_data;
            miss_done_q  <= done_d;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        ST_FILL: begin
          repl_ptr_q <= (repl_ptr_q == RW'(CACHE_SIZE - 1)) ? '0 : repl_ptr_q + RW'(1);
          state_q    <= ST_IDLE;
          busy_q     <= 1'b0;
        end
        ST_SKIP: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.miss_done  = miss_done_q;
  assign bus.mem_en     = mem_en_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.fill_valid = fill_valid_q;
  assign bus.fill_index = fill_index_q;
  assign bus.fill_tag   = fill_tag_q;
  assign bus.fill_data  = fill_data_q;
  assign bus.busy       = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_l1_fill_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_l1_fill_unit
//  Description : Directed self-checking bench for l1_fill_unit with a
//                two-cycle chunk BRAM model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_l1_fill_unit;
  import l1_fill_unit_pkg::*;

  localparam int PORTS       = 4;
  localparam int CACHE_SIZE  = 16;
  localparam int MEM_LATENCY = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  int n_vec  = 0;
  int n_err  = 0;
  int n_en   = 0;
  int n_fill = 0;
  int n_done = 0;

  logic              p1_v = 1'b0, p2_v = 1'b0;
  logic [ADDR_W-1:0] p1_a = '0,   p2_a = '0;

  l1_fill_unit_if #(.PORTS(PORTS), .CACHE_SIZE(CACHE_SIZE)) bus ();

  l1_fill_unit #(
    .PORTS       (PORTS),
    .CACHE_SIZE  (CACHE_SIZE),
    .MEM_LATENCY (MEM_LATENCY)
  ) dut (
    .clk_in (clk),
    .rst_in (rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // Chunk BRAM: data for the strobed address appears two cycles after the
  // strobe and only then; other cycles carry junk.
  always @(posedge clk) begin
    p1_v <= bus.mem_en;
    p1_a <= bus.mem_addr;
    p2_v <= p1_v;
    p2_a <= p1_a;
    if (bus.mem_en)          n_en   <= n_en + 1;
    if (bus.fill_valid)      n_fill <= n_fill + 1;
    if (bus.miss_done != '0) n_done <= n_done + 1;
  end

  function automatic BlockType mem_word(input logic [ADDR_W-1:0] a);
    return a[7:0] ^ 8'h5A;
  endfunction

  assign bus.mem_data = p2_v ? mem_word(p2_a) : 8'hEE;

  function automatic BlockPos mk(input int x, input int y, input int z);
    BlockPos p;
    p.x = coord_t'(x);
    p.y = coord_t'(y);
    p.z = coord_t'(z);
    return p;
  endfunction

  // Offset-binary address by arithmetic: each coordinate plus half a chunk.
  function automatic logic [ADDR_W-1:0] exp_addr(input BlockPos p);
    int a;
    a = ((int'($signed(p.x)) + 8) << 8) + ((int'($signed(p.y)) + 8) << 4) +
        (int'($signed(p.z)) + 8);
    return a[ADDR_W-1:0];
  endfunction

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done();
    int i;
    i = 0;
    do begin
      tick();
      i++;
    end while (bus.miss_done == '0 && i < 20);
    check_vec("done_seen", 32'(bus.miss_done != '0), 32'd1);
  endtask

  BlockPos cur [PORTS];
  int      snap_en, snap_fill, snap_done;

  initial begin
    bus.miss_valid = '0;
    bus.miss_addr  = '0;

    // Reset state
    tick(); tick();
    check_vec("rst_busy",   32'(bus.busy),       32'd0);
    check_vec("rst_mem_en", 32'(bus.mem_en),     32'd0);
    check_vec("rst_fill",   32'(bus.fill_valid), 32'd0);
    check_vec("rst_done",   32'(bus.miss_done),  32'd0);
    rst_n = 1'b1;
    tick(); tick();

    // Single miss: port 2 at (1,-3,5)
    bus.miss_addr[2]  = mk(1, -3, 5);
    bus.miss_valid    = 4'b0100;
    tick();
    check_vec("s_mem_en",   32'(bus.mem_en),   32'd1);
    check_vec("s_mem_addr", 32'(bus.mem_addr), 32'h95D);
    check_vec("s_busy",     32'(bus.busy),     32'd1);
    tick();
    check_vec("s_early_fill", 32'(bus.fill_valid), 32'd0);
    tick();
    check_vec("s_early_fill2", 32'(bus.fill_valid), 32'd0);
    tick();
    check_vec("s_fill",  32'(bus.fill_valid), 32'd1);
    check_vec("s_index", 32'(bus.fill_index), 32'd0);
    check_vec("s_tag",   32'(bus.fill_tag),   32'h1D5);
    check_vec("s_data",  32'(bus.fill_data),  32'h07);
    check_vec("s_done",  32'(bus.miss_done),  32'b0100);
    bus.miss_valid = '0;
    tick();
    check_vec("s_idle", 32'(bus.busy), 32'd0);

    // Invalid coordinate: port 1 at (-8,0,0)
    snap_en = n_en; snap_fill = n_fill;
    bus.miss_addr[1] = mk(-8, 0, 0);
    bus.miss_valid   = 4'b0010;
    tick();
    check_vec("i_done",   32'(bus.miss_done),  32'b0010);
    check_vec("i_mem_en", 32'(bus.mem_en),     32'd0);
    check_vec("i_fill",   32'(bus.fill_valid), 32'd0);
    bus.miss_valid = '0;
    tick();
    check_vec("i_idle", 32'(bus.busy), 32'd0);
    tick();
    check_vec("i_no_en",   n_en - snap_en,     32'd0);
    check_vec("i_no_fill", n_fill - snap_fill, 32'd0);

    // Coalescing: ports 0 and 3 at (2,2,2); pointer is at 2 so port 3 wins
    snap_en = n_en; snap_fill = n_fill;
    bus.miss_addr[0] = mk(2, 2, 2);
    bus.miss_addr[3] = mk(2, 2, 2);
    bus.miss_valid   = 4'b1001;
    wait_done();
    check_vec("c_done",  32'(bus.miss_done),  32'b1001);
    check_vec("c_index", 32'(bus.fill_index), 32'd1);
    check_vec("c_tag",   32'(bus.fill_tag),   32'hAAA & 32'h000 | 32'(mk(2, 2, 2)));
    bus.miss_valid = '0;
    tick(); tick();
    check_vec("c_one_en",   n_en - snap_en,     32'd1);
    check_vec("c_one_fill", n_fill - snap_fill, 32'd1);

    // Backpressure: port 0 arrives during port 1's wait
    bus.miss_addr[1] = mk(3, 3, 3);
    bus.miss_valid   = 4'b0010;
    tick(); tick();
    bus.miss_addr[0] = mk(4, 4, 4);
    bus.miss_valid   = 4'b0011;
    tick(); tick();
    check_vec("b_done1",  32'(bus.miss_done),  32'b0010);
    check_vec("b_index1", 32'(bus.fill_index), 32'd2);
    bus.miss_valid[1] = 1'b0;
    tick();
    check_vec("b_gap_en", 32'(bus.mem_en), 32'd0);
    tick();
    check_vec("b_mem_en",   32'(bus.mem_en),   32'd1);
    check_vec("b_mem_addr", 32'(bus.mem_addr), 32'hCCC);
    wait_done();
    check_vec("b_done0",  32'(bus.miss_done),  32'b0001);
    check_vec("b_index0", 32'(bus.fill_index), 32'd3);
    check_vec("b_data0",  32'(bus.fill_data),  32'h96);
    bus.miss_valid = '0;
    tick();

    // Reset in the middle of a wait
    bus.miss_addr[2] = mk(5, 6, 7);
    bus.miss_valid   = 4'b0100;
    tick(); tick();
    rst_n          = 1'b0;
    bus.miss_valid = '0;
    #1;
    check_vec("r_busy",   32'(bus.busy),       32'd0);
    check_vec("r_mem_en", 32'(bus.mem_en),     32'd0);
    check_vec("r_fill",   32'(bus.fill_valid), 32'd0);
    check_vec("r_done",   32'(bus.miss_done),  32'd0);
    snap_en = n_en; snap_fill = n_fill; snap_done = n_done;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    check_vec("r_no_fill", n_fill - snap_fill, 32'd0);
    check_vec("r_no_done", n_done - snap_done, 32'd0);
    check_vec("r_no_en",   n_en - snap_en,     32'd0);

    // Round-robin with continuous requests; 17 fills wrap the index
    for (int k = 0; k < PORTS; k++) begin
      cur[k]           = mk(k, 0, -1);
      bus.miss_addr[k] = cur[k];
    end
    bus.miss_valid = 4'hF;
    for (int n = 0; n < 17; n++) begin
      int k;
      k = n % PORTS;
      wait_done();
      check_vec("rr_done",  32'(bus.miss_done),  32'(1 << k));
      check_vec("rr_index", 32'(bus.fill_index), 32'(n % CACHE_SIZE));
      check_vec("rr_tag",   32'(bus.fill_tag),   32'(cur[k]));
      check_vec("rr_data",  32'(bus.fill_data),  32'(exp_addr(cur[k]) [7:0] ^ 8'h5A));
      bus.miss_valid[k] = 1'b0;
      tick(); tick();
      cur[k]            = mk(k, (n / PORTS + 1) % 8, -1);
      bus.miss_addr[k]  = cur[k];
      bus.miss_valid[k] = 1'b1;
    end
    bus.miss_valid = '0;
    for (int i = 0; i < 10; i++) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/l1_fill_unit.md
# l1_fill_unit

Miss handler and refill engine for the multi-port L1 block cache. Consumers whose cache lookup returned `valid = 0` post the missed `BlockPos` here. The unit arbitrates round-robin among them and reads the block type from chunk BRAM. It then writes one entry into the cache through a single write port, using cyclic replacement. It sits between the cache's consumers and chunk memory, and drives the cache's fill side.

## Interface
- `PORTS`, 4, number of requesting ports (matches cache `PORTS`)
- `CACHE_SIZE`, 16, cache entries; must be ≥ 2
- `MEM_LATENCY`, 2, chunk BRAM read latency in cycles; must be ≥ 1
- `clk_in`  in  1  single clock
- `rst_in`  in  1  reset, asynchronous, active-low
- `miss_valid`  in  PORTS  port i has an outstanding miss
- `miss_addr`  in  PORTS×BlockPos  missed position per port
- `miss_done`  out  PORTS  one-cycle pulse: miss of port i resolved
- `mem_en`  out  1  chunk BRAM read strobe
- `mem_addr`  out  3·log2(CHUNK_WIDTH)  linear chunk address
- `mem_data`  in  BlockType  read data, valid MEM_LATENCY cycles after `mem_en`
- `fill_valid`  out  1  write strobe into cache
- `fill_index`  out  log2(CACHE_SIZE)  entry to overwrite
- `fill_tag`  out  BlockPos  tag written
- `fill_data`  out  BlockType  block written
- `busy`  out  1  state ≠ IDLE

## Operation
- States: IDLE, READ, WAIT, FILL, SKIP.
- **IDLE:** if any `miss_valid` is set, grant the first set port at or after `rr_ptr` (wrapping). Latch its index and address, then set `rr_ptr` to grant+1 mod PORTS.
  - If any coordinate of the latched address equals TAG_INVALID (−CHUNK_WIDTH/2), go to SKIP.
  - Otherwise go to READ.
- **READ:** one cycle.
  - `mem_en` = 1.
  - `mem_addr` = {x, y, z}, each coordinate in offset binary (MSB inverted).
  - Go to WAIT, with the counter loaded to MEM_LATENCY−1.
- **WAIT:** counts down. Capture `mem_data` in the cycle the counter reaches 0, then go to FILL.
- **FILL:** one cycle.
  - `fill_valid` = 1, `fill_index` = `repl_ptr`, `fill_tag` = latched address, `fill_data` = captured data.
  - Pulse `miss_done` for the granted port. Also pulse it for every other port whose `miss_valid`=1 and whose `miss_addr` equals the latched address (coalescing).
  - `repl_ptr` increments, wrapping CACHE_SIZE−1→0.
  - Go to IDLE.
- **SKIP:** one cycle.
  - Pulse `miss_done` for the granted port only.
  - No memory access, no fill, `repl_ptr` unchanged.
  - Go to IDLE.
- **Requester rule:** hold `miss_valid` high with a stable `miss_addr` until `miss_done` is seen.
  - If `miss_valid` drops early, the fill still completes and `miss_done` still pulses.
- **Reset (any time):** all outputs 0, state IDLE, `rr_ptr` = 0, `repl_ptr` = 0, counter 0.
  - A reset mid-operation aborts without a fill or a `miss_done`.
  - `mem_data` returned after reset is ignored.

## Timing
- All outputs are registered. `miss_done` and `fill_valid` are coincident.
- Request in IDLE sampled at cycle t:
  - `mem_en` in cycle t+1.
  - Data captured in cycle t+1+MEM_LATENCY.
  - `fill_valid`/`miss_done` in cycle t+2+MEM_LATENCY.
  - IDLE again at t+3+MEM_LATENCY.
- Invalid coordinate: `miss_done` in cycle t+1, IDLE at t+2.
- One fill is in flight at most. Throughput is one fill per MEM_LATENCY+3 cycles.
- A requester deasserts in the cycle after `miss_done`, so it is never re-granted.
- Requests arriving while not IDLE wait. No request is dropped.

## Structure
- Shared types package (types.sv) holds:
  - `BlockPos`, `BlockType`, `BLOCK_AIR`, `CHUNK_WIDTH`.
  - New: coordinate constant `TAG_INVALID`.
  - New: function `block_pos_to_addr` (offset-binary concatenation).
  - The cache reset logic uses the same `TAG_INVALID`.
- Sub-module `rr_arbiter #(N)`: combinational grant from request vector and pointer, plus a one-hot/index output.

## Test plan
- Reset values: assert `rst_in`=0 mid-WAIT → all outputs 0 immediately. After release, data arriving at the old return time produces no `fill_valid`.
- Single miss, MEM_LATENCY=2: port 2 requests (1,−3,5) at cycle 0 → `mem_en` at cycle 1 with `mem_addr` = {9,5,13} (CHUNK_WIDTH=16). `mem_data`=7 at cycle 3 → cycle 4 shows `fill_valid`, `fill_index`=0, `fill_tag`=(1,−3,5), `fill_data`=7, `miss_done`=0b0100.
- Round-robin: all 4 ports request distinct addresses continuously → grants in order 0,1,2,3. `fill_index` goes 0,1,2,3. A fifth fill after 12 more fills wraps `fill_index` to 0.
- Coalescing: ports 0 and 3 request the same address → one `mem_en`, one fill, `miss_done`=0b1001.
- Invalid coordinate: port 1 requests (−8,0,0) → `miss_done`=0b0010 at t+1, no `mem_en`, no fill, `repl_ptr` unchanged.
- Backpressure: port 0 requests during port 1's WAIT → served immediately after port 1's FILL. Port 0's `mem_en` appears at port 1's FILL cycle + 2.
